// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Strobe vectors are ordered {ce_n, oe_n, we_n}.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    D_RD,
    D_WR,
    D_WR_HOLD
  } state_e;

  localparam int WAIT_W = 4;

  localparam logic [2:0] STRB_IDLE = 3'b111;
  localparam logic [2:0] STRB_RD   = 3'b001;
  localparam logic [2:0] STRB_WR   = 3'b010;

endpackage

// File: rtl/sram_arbiter_ifetch_buf.sv
// One-entry instruction fetch buffer: tag, data and valid bit.
// Filled by each completed fetch, cleared by a write to the tag.
module ifetch_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inv,
  input  logic [ADDR_W-1:0] inv_addr,
  input  logic [ADDR_W-1:0] look_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              vld_q, vld_d;

  // Next entry: fill on fetch completion, drop on write to the tag
  always_comb begin
    tag_d = tag_q;
    dat_d = dat_q;
    vld_d = vld_q;
    if (fill) begin
      tag_d = fill_addr;
      dat_d = fill_data;
      vld_d = 1'b1;
    end else if (inv && inv_addr == tag_q) begin
      vld_d = 1'b0;
    end
  end

  // Entry registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q <= '0;
      dat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign hit  = vld_q && (look_addr == tag_q);
  assign data = dat_q;

endmodule

// File: rtl/sram_arbiter.sv
// Fetch/data arbiter onto one asynchronous SRAM port.
// Optional fetch buffer: define SRAM_ARB_IFETCH_BUF_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_conflict,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [2:0]        strb_q, strb_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] ird_q, ird_d;
  logic [DATA_W-1:0] drd_q, drd_d;
  logic              ivld_q, ivld_d;
  logic              dvld_q, dvld_d;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;

`ifdef SRAM_ARB_IFETCH_BUF_EN
  ifetch_buffer #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ibuf (
    .clk      (clk),
    .rst      (rst),
    .fill     (state_q == IF_RD && cnt_q == '0),
    .fill_addr(addr_q),
    .fill_data(sram_dq_i),
    .inv      (state_q == IDLE && d_req && d_we),
    .inv_addr (d_addr),
    .look_addr(if_addr),
    .hit      (buf_hit),
    .data     (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // Arbitration, wait counting and registered strobe values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    strb_d  = strb_q;
    oe_d    = oe_q;
    ird_d   = ird_q;
    drd_d   = drd_q;
    ivld_d  = 1'b0;
    dvld_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req) begin
          addr_d = d_addr;
          cnt_d  = WAIT_LD;
          if (d_we) begin
            wdat_d  = d_wdata;
            state_d = D_WR;
            strb_d  = STRB_WR;
            oe_d    = 1'b1;
          end else begin
            state_d = D_RD;
            strb_d  = STRB_RD;
          end
        end else if (if_req) begin
          if (buf_hit) begin
            ivld_d = 1'b1;
            ird_d  = buf_data;
          end else begin
            addr_d  = if_addr;
            cnt_d   = WAIT_LD;
            state_d = IF_RD;
            strb_d  = STRB_RD;
          end
        end
      end
      IF_RD, D_RD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          strb_d  = STRB_IDLE;
          if (state_q == IF_RD) begin
            ird_d  = sram_dq_i;
            ivld_d = 1'b1;
          end else begin
            drd_d  = sram_dq_i;
            dvld_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      D_WR: begin
        if (cnt_q == '0) begin
          state_d = D_WR_HOLD;
          strb_d  = STRB_IDLE;
          dvld_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      D_WR_HOLD: begin
        state_d = IDLE;
        oe_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
        strb_d  = STRB_IDLE;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      strb_q  <= STRB_IDLE;
      oe_q    <= 1'b0;
      ird_q   <= '0;
      drd_q   <= '0;
      ivld_q  <= 1'b0;
      dvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      strb_q  <= strb_d;
      oe_q    <= oe_d;
      ird_q   <= ird_d;
      drd_q   <= drd_d;
      ivld_q  <= ivld_d;
      dvld_q  <= dvld_d;
    end
  end

  assign mem_conflict = if_req &
    ((state_q == IDLE && d_req) ||
     state_q == D_RD || state_q == D_WR ||
     state_q == D_WR_HOLD);

  assign if_rdata   = ird_q;
  assign if_valid   = ivld_q;
  assign d_rdata    = drd_q;
  assign d_valid    = dvld_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdat_q;
  assign sram_dq_oe = oe_q;
  assign sram_ce_n  = strb_q[2];
  assign sram_oe_n  = strb_q[1];
  assign sram_we_n  = strb_q[0];

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM model.
// Main instance WAIT_CYCLES=1, second instance WAIT_CYCLES=0.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Main instance signals
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [17:0] if_addr = '0, d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] if_rdata, d_rdata, s_dq_o;
  logic [15:0] s_dq_i = '0;
  logic        if_valid, d_valid, conflict;
  logic [17:0] s_addr;
  logic        s_oe, s_ce_n, s_oe_n, s_we_n;

  // Zero-wait instance signals
  logic        z_if_req = 0;
  logic [17:0] z_if_addr = '0;
  logic [15:0] z_if_rdata, z_d_rdata, z_dq_o;
  logic [15:0] z_dq_i = '0;
  logic        z_if_valid, z_d_valid, z_conflict;
  logic [17:0] z_addr;
  logic        z_oe, z_ce_n, z_oe_n, z_we_n;

  sram_arbiter #(.DATA_W(16), .ADDR_W(18), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_conflict(conflict),
    .sram_addr(s_addr), .sram_dq_o(s_dq_o), .sram_dq_i(s_dq_i),
    .sram_dq_oe(s_oe), .sram_ce_n(s_ce_n),
    .sram_oe_n(s_oe_n), .sram_we_n(s_we_n)
  );

  sram_arbiter #(.DATA_W(16), .ADDR_W(18), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(z_if_req), .if_addr(z_if_addr),
    .if_rdata(z_if_rdata), .if_valid(z_if_valid),
    .d_req(1'b0), .d_we(1'b0), .d_addr(18'h0),
    .d_wdata(16'h0), .d_rdata(z_d_rdata), .d_valid(z_d_valid),
    .mem_conflict(z_conflict),
    .sram_addr(z_addr), .sram_dq_o(z_dq_o), .sram_dq_i(z_dq_i),
    .sram_dq_oe(z_oe), .sram_ce_n(z_ce_n),
    .sram_oe_n(z_oe_n), .sram_we_n(z_we_n)
  );

  // SRAM models: write on edges with ce_n/we_n low, read data
  // updated on the falling edge while oe_n is low
  logic [15:0] mem1 [logic [17:0]];
  logic [15:0] mem0 [logic [17:0]];

  always @(posedge clk) begin
    if (!s_ce_n && !s_we_n && s_oe) mem1[s_addr] = s_dq_o;
  end

  always @(negedge clk) begin
    if (!s_ce_n && !s_oe_n && mem1.exists(s_addr)) s_dq_i = mem1[s_addr];
    else s_dq_i = 16'h0;
    if (!z_ce_n && !z_oe_n && mem0.exists(z_addr)) z_dq_i = mem0[z_addr];
    else z_dq_i = 16'h0;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the main instance; reports latency and strobe counts
  task automatic access(input bit f, input bit we,
                        input logic [17:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output int lat,
                        output int ce_lo, output int we_lo,
                        output bit hold_ok);
    bit done;
    if (f) begin
      if_req = 1; if_addr = a;
    end else begin
      d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    end
    lat = 0; ce_lo = 0; we_lo = 0; hold_ok = 0; done = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (!s_ce_n) ce_lo++;
      if (!s_we_n) we_lo++;
      done = f ? if_valid : d_valid;
    end
    if (done && !f && we)
      hold_ok = s_oe && s_we_n && s_ce_n && (s_dq_o == wd);
    rd = f ? if_rdata : d_rdata;
    if_req = 0;
    d_req = 0;
    d_we = 0;
  endtask

  typedef struct {
    bit          f;
    bit          we;
    logic [17:0] a;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [15:0] rd;
    int lat, ce_lo, we_lo, dcyc, icyc;
    bit hold_ok;
    logic [15:0] zexp[4];

    vecs[0] = '{0, 1, 18'h00100, 16'h1111, 16'h0000};
    vecs[1] = '{0, 1, 18'h2AAAA, 16'hCAFE, 16'h0000};
    vecs[2] = '{0, 0, 18'h00100, 16'h0000, 16'h1111};
    vecs[3] = '{1, 0, 18'h2AAAA, 16'h0000, 16'hCAFE};
    vecs[4] = '{0, 1, 18'h00000, 16'h0F0F, 16'h0000};
    vecs[5] = '{1, 0, 18'h00000, 16'h0000, 16'h0F0F};
    vecs[6] = '{0, 0, 18'h2AAAA, 16'h0000, 16'hCAFE};
    vecs[7] = '{0, 1, 18'h2AAAA, 16'h5555, 16'h0000};
    vecs[8] = '{1, 0, 18'h2AAAA, 16'h0000, 16'h5555};
    vecs[9] = '{0, 0, 18'h00000, 16'h0000, 16'h0F0F};

    mem1[18'h00010] = 16'hA5C3;
    mem1[18'h00011] = 16'h7777;
    mem1[18'h00020] = 16'h2020;
    zexp = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
    for (int i = 0; i < 4; i++) mem0[18'(i)] = zexp[i];

    // Reset state
    repeat (3) tick();
    chk("rst_strobes", {s_ce_n, s_oe_n, s_we_n}, 3'b111);
    chk("rst_dq_oe", s_oe, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_dq_o", s_dq_o, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    chk("rst_valid", {if_valid, d_valid}, 0);
    rst = 1;
    tick();

    // Table-driven accesses
    for (int i = 0; i < 10; i++) begin
      access(vecs[i].f, vecs[i].we, vecs[i].a, vecs[i].wd,
             rd, lat, ce_lo, we_lo, hold_ok);
      chk($sformatf("vec%0d_lat", i), lat, 3);
      if (vecs[i].we) chk($sformatf("vec%0d_hold", i), hold_ok, 1);
      else chk($sformatf("vec%0d_data", i), rd, vecs[i].exp);
      tick();
    end

    // Fetch latency
    access(1, 0, 18'h00010, 0, rd, lat, ce_lo, we_lo, hold_ok);
    chk("fetch_lat", lat, 3);
    chk("fetch_data", rd, 16'hA5C3);
    chk("fetch_ce_cycles", ce_lo, 2);
    tick();

    // Write to top address then read it back
    access(0, 1, 18'h3FFFF, 16'h1234, rd, lat, ce_lo, we_lo, hold_ok);
    chk("wr_lat", lat, 3);
    chk("wr_we_low", we_lo, 2);
    chk("wr_hold", hold_ok, 1);
    tick();
    chk("wr_oe_release", s_oe, 0);
    access(0, 0, 18'h3FFFF, 0, rd, lat, ce_lo, we_lo, hold_ok);
    chk("rdback_lat", lat, 3);
    chk("rdback_data", rd, 16'h1234);
    tick();

    // Simultaneous fetch and data write
    if_req = 1; if_addr = 18'h00011;
    d_req = 1; d_we = 1; d_addr = 18'h00040; d_wdata = 16'hBEEF;
    #1;
    chk("conf_idle", conflict, 1);
    dcyc = 0; icyc = 0;
    for (int c = 1; c <= 20 && icyc == 0; c++) begin
      tick();
      chk($sformatf("conf_c%0d", c), conflict, (dcyc == 0) ? 1 : 0);
      if (if_valid) begin
        icyc = c;
        if_req = 0;
      end
      if (d_valid) begin
        dcyc = c;
        d_req = 0; d_we = 0;
      end
    end
    chk("conf_dvalid_cyc", dcyc, 3);
    chk("conf_ivalid_cyc", icyc, 7);
    chk("conf_fetch_data", if_rdata, 16'h7777);
    chk("conf_wr_mem", mem1.exists(18'h00040) ? mem1[18'h00040] : 16'h0,
        16'hBEEF);
    tick();

    // Reset in the middle of a write
    d_req = 1; d_we = 1; d_addr = 18'h00055; d_wdata = 16'h9999;
    tick();
    chk("mid_we_low", s_we_n, 0);
    rst = 0; d_req = 0; d_we = 0;
    tick();
    chk("mid_strobes", {s_ce_n, s_oe_n, s_we_n}, 3'b111);
    chk("mid_dq_oe", s_oe, 0);
    chk("mid_dvalid", d_valid, 0);
    tick();
    rst = 1;
    tick();
    chk("mid_post_dvalid", d_valid, 0);
    chk("mid_post_strobes", {s_ce_n, s_oe_n, s_we_n}, 3'b111);
    access(1, 0, 18'h00010, 0, rd, lat, ce_lo, we_lo, hold_ok);
    chk("mid_fetch_lat", lat, 3);
    chk("mid_fetch_data", rd, 16'hA5C3);
    tick();

    // Zero wait states: back-to-back fetches
    begin
      int n, lastc;
      n = 0; lastc = 0;
      z_if_req = 1; z_if_addr = 18'h0;
      for (int c = 1; c <= 20 && n < 4; c++) begin
        tick();
        if (z_if_valid) begin
          chk($sformatf("z_data%0d", n), z_if_rdata, zexp[n]);
          chk($sformatf("z_gap%0d", n), c - lastc, 2);
          lastc = c;
          n++;
          z_if_addr = 18'(n);
          if (n == 4) z_if_req = 0;
        end
      end
      z_if_req = 0;
      chk("z_count", n, 4);
    end
    tick();

`ifdef SRAM_ARB_IFETCH_BUF_EN
    // Fetch buffer hit and write invalidation
    access(1, 0, 18'h00020, 0, rd, lat, ce_lo, we_lo, hold_ok);
    chk("buf_miss_lat", lat, 3);
    chk("buf_miss_data", rd, 16'h2020);
    tick();
    access(1, 0, 18'h00020, 0, rd, lat, ce_lo, we_lo, hold_ok);
    chk("buf_hit_lat", lat, 1);
    chk("buf_hit_ce", ce_lo, 0);
    chk("buf_hit_data", rd, 16'h2020);
    tick();
    access(0, 1, 18'h00020, 16'h3030, rd, lat, ce_lo, we_lo, hold_ok);
    tick();
    access(1, 0, 18'h00020, 0, rd, lat, ce_lo, we_lo, hold_ok);
    chk("buf_inv_lat", lat, 3);
    chk("buf_inv_ce", ce_lo, 2);
    chk("buf_inv_data", rd, 16'h3030);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
